score_ctrl: RTL and testbench
=============================

Name: score_ctrl

Overview:
- Producer side of the score interface consumed by the background/score renderer.
- Owns the Pong match state machine and both player score counters.
- Reacts to goal pulses from ball logic and the start button; sequences serve, play, post-point pause and game over.
- Drives player1_score / player2_score (single BCD digit each) plus ball enable and serve direction to the ball/paddle logic.

Parameters:
- WIN_SCORE, 9: score that ends the match; legal range 1..9 (single displayed digit).
- PAUSE_FRAMES, 60: frames spent in PAUSE after each point; legal range 1..255.

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  asynchronous, active-low reset
- vblnk_in  in  1  vertical blank from timing chain; a rising edge is one frame tick
- start_btn  in  1  debounced start/serve button, level
- goal_p1  in  1  one-cycle pulse: ball passed right edge, point to player 1
- goal_p2  in  1  one-cycle pulse: ball passed left edge, point to player 2
- player1_score  out  4  player 1 score, 0..WIN_SCORE
- player2_score  out  4  player 2 score, 0..WIN_SCORE
- ball_enable  out  1  1 only in PLAY; ball logic freezes and recentres when 0
- serve_dir  out  1  0 = serve toward player 1 (left), 1 = toward player 2 (right)
- game_over  out  1  1 in GAME_OVER
- winner  out  1  0 = player 1, 1 = player 2; valid while game_over = 1

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; all outputs are registered.
  - Scores = 0, ball_enable = 0, serve_dir = 1, game_over = 0, winner = 0.
  - Pause counter and both edge-detector history registers = 0.
- Internal rising-edge detectors on vblnk_in (frame_tick) and start_btn (start_pe).
  - Each edge pulse is registered: it appears 1 cycle after the input rises.
  - A button held through reset release produces no pulse.
- States and transitions:
  - IDLE: scores held at 0. start_pe -> SERVE.
  - SERVE: ball_enable = 0. start_pe -> PLAY.
  - PLAY: ball_enable = 1. A goal pulse updates the score and moves to PAUSE; see the goal rules below.
  - PAUSE: ball_enable = 0. The counter increments on each frame_tick. When it reaches PAUSE_FRAMES, the counter clears and the state moves to SERVE. Goals and start_pe are ignored.
  - GAME_OVER: game_over = 1, winner held. start_pe -> IDLE, which clears scores, serve_dir = 1, winner = 0.
- Goal rules in PLAY:
  - goal_p1 alone: player1_score + 1, serve_dir <= 0.
  - goal_p2 alone: player2_score + 1, serve_dir <= 1.
  - The incremented score reaching WIN_SCORE goes to GAME_OVER, with winner set to the scoring player. Otherwise the next state is PAUSE.
  - Latency: goal pulse in cycle N gives the new score, the new state and ball_enable = 0 in cycle N+1.
  - goal_p1 and goal_p2 in the same cycle: no score change, serve_dir unchanged, go to PAUSE (replayed point).
- Goals outside PLAY are ignored, including a goal pulse coincident with the PLAY entry cycle.
- Scores saturate at WIN_SCORE and never wrap. Arithmetic is 4-bit unsigned.
- frame_tick and start_pe in the same cycle: each is used only by the state that consumes it.
- The pause counter is 8 bits. It is cleared on entry to PAUSE and on reset.

Decomposition:
- Shared package (alongside vga_pkg, new game_pkg):
  - game_state_t enum {IDLE, SERVE, PLAY, PAUSE, GAME_OVER}
  - SERVE_LEFT / SERVE_RIGHT constants
  - default WIN_SCORE and PAUSE_FRAMES
- One sub-module: edge_detect (registered rising-edge pulse, async active-low reset), instantiated twice.
- FSM and counters stay in score_ctrl.

Test Plan:
- Reset with start_btn held high, then release rst -> no transition; IDLE, scores 0/0, serve_dir = 1, ball_enable = 0.
- start pulse twice, then goal_p1 one cycle -> next cycle player1_score = 1, ball_enable = 0, serve_dir = 0. After 60 vblnk rising edges the state is SERVE.
- In PLAY, goal_p1 and goal_p2 in the same cycle -> scores unchanged, serve_dir unchanged, state PAUSE.
- goal pulses during SERVE and PAUSE -> scores unchanged.
- Drive player 2 to 8, then goal_p2 -> player2_score = 9, game_over = 1, winner = 1, no PAUSE. A further goal_p2 leaves the score at 9.
- In GAME_OVER, start pulse -> IDLE, both scores 0. Asserting rst mid-PAUSE (counter = 30) -> outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-level types and defaults for the Pong match logic.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        PAUSE     = 3'd3,
        GAME_OVER = 3'd4
    } game_state_t;

    localparam logic SERVE_LEFT  = 1'b0;
    localparam logic SERVE_RIGHT = 1'b1;

    localparam int WIN_SCORE_DEF    = 9;
    localparam int PAUSE_FRAMES_DEF = 60;

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector; the first cycle after reset only samples,
// so a level already high at reset release never yields a pulse.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic pulse_o
);

    logic prev_q;
    logic armed_q;
    logic pulse_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= sig_i;
            armed_q <= 1'b1;
            pulse_q <= armed_q & sig_i & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/score_ctrl.sv
// Pong match controller: sequences serve/play/pause/game-over and owns both
// player score digits; every output is driven straight from a register.
module score_ctrl
    import game_pkg::*;
#(
    parameter int WIN_SCORE    = WIN_SCORE_DEF,
    parameter int PAUSE_FRAMES = PAUSE_FRAMES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk_in,
    input  logic       start_btn,
    input  logic       goal_p1,
    input  logic       goal_p2,
    output logic [3:0] player1_score,
    output logic [3:0] player2_score,
    output logic       ball_enable,
    output logic       serve_dir,
    output logic       game_over,
    output logic       winner
);

    localparam logic [3:0] WIN_Q    = 4'(WIN_SCORE);
    localparam logic [7:0] PAUSE_LQ = 8'(PAUSE_FRAMES - 1);

    game_state_t state_q, state_d;
    logic [3:0]  p1_q, p1_d;
    logic [3:0]  p2_q, p2_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        dir_q, dir_d;
    logic        winner_q, winner_d;
    logic        ball_en_q, ball_en_d;
    logic        over_q, over_d;
    logic        frame_tick;
    logic        start_pe;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN_Q) ? s : s + 4'd1;
    endfunction

    edge_detect u_vblnk_edge (
        .clk     (clk),
        .rst     (rst),
        .sig_i   (vblnk_in),
        .pulse_o (frame_tick)
    );

    edge_detect u_start_edge (
        .clk     (clk),
        .rst     (rst),
        .sig_i   (start_btn),
        .pulse_o (start_pe)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            p1_q      <= 4'd0;
            p2_q      <= 4'd0;
            cnt_q     <= 8'd0;
            dir_q     <= SERVE_RIGHT;
            winner_q  <= 1'b0;
            ball_en_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            winner_q  <= winner_d;
            ball_en_q <= ball_en_d;
            over_q    <= over_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        winner_d = winner_q;

        unique case (state_q)
            IDLE: begin
                p1_d = 4'd0;
                p2_d = 4'd0;
                if (start_pe) state_d = SERVE;
            end
            SERVE: begin
                if (start_pe) state_d = PLAY;
            end
            PLAY: begin
                // A simultaneous goal on both sides is a replayed point.
                if (goal_p1 && goal_p2) begin
                    state_d = PAUSE;
                    cnt_d   = 8'd0;
                end else if (goal_p1) begin
                    p1_d  = sat_inc(p1_q);
                    dir_d = SERVE_LEFT;
                    cnt_d = 8'd0;
                    if (p1_d == WIN_Q) begin
                        state_d  = GAME_OVER;
                        winner_d = 1'b0;
                    end else begin
                        state_d = PAUSE;
                    end
                end else if (goal_p2) begin
                    p2_d  = sat_inc(p2_q);
                    dir_d = SERVE_RIGHT;
                    cnt_d = 8'd0;
                    if (p2_d == WIN_Q) begin
                        state_d  = GAME_OVER;
                        winner_d = 1'b1;
                    end else begin
                        state_d = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (frame_tick) begin
                    if (cnt_q == PAUSE_LQ) begin
                        cnt_d   = 8'd0;
                        state_d = SERVE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            GAME_OVER: begin
                if (start_pe) begin
                    state_d  = IDLE;
                    p1_d     = 4'd0;
                    p2_d     = 4'd0;
                    dir_d    = SERVE_RIGHT;
                    winner_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        ball_en_d = (state_d == PLAY);
        over_d    = (state_d == GAME_OVER);
    end

    assign player1_score = p1_q;
    assign player2_score = p2_q;
    assign ball_enable   = ball_en_q;
    assign serve_dir     = dir_q;
    assign game_over     = over_q;
    assign winner        = winner_q;

endmodule

// File: tb/tb_score_ctrl.sv
// Directed test-plan sequence plus randomized play, checked every cycle
// against a behavioural match model.
module tb_score_ctrl;

    localparam int WIN = 9;
    localparam int PF  = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vblnk_in = 1'b0;
    logic       start_btn = 1'b0;
    logic       goal_p1 = 1'b0;
    logic       goal_p2 = 1'b0;
    logic [3:0] player1_score;
    logic [3:0] player2_score;
    logic       ball_enable;
    logic       serve_dir;
    logic       game_over;
    logic       winner;

    int compared = 0;
    int mismatched = 0;
    bit check_en = 0;

    score_ctrl #(.WIN_SCORE(WIN), .PAUSE_FRAMES(PF)) dut (
        .clk           (clk),
        .rst           (rst),
        .vblnk_in      (vblnk_in),
        .start_btn     (start_btn),
        .goal_p1       (goal_p1),
        .goal_p2       (goal_p2),
        .player1_score (player1_score),
        .player2_score (player2_score),
        .ball_enable   (ball_enable),
        .serve_dir     (serve_dir),
        .game_over     (game_over),
        .winner        (winner)
    );

    always #5 clk = ~clk;

    // Behavioural model: match mode, scores, and button/frame events that
    // become visible to the match one cycle after the input rises.
    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_PAUSE = 3, M_OVER = 4;
    int m_mode, m_s1, m_s2, m_dir, m_win, m_frames;
    bit m_tick_pend, m_start_pend, m_vb_prev, m_st_prev, m_armed;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = M_IDLE; m_s1 = 0; m_s2 = 0; m_dir = 1; m_win = 0; m_frames = 0;
            m_tick_pend = 0; m_start_pend = 0; m_vb_prev = 0; m_st_prev = 0; m_armed = 0;
        end else begin
            case (m_mode)
                M_IDLE:  if (m_start_pend) m_mode = M_SERVE;
                M_SERVE: if (m_start_pend) m_mode = M_PLAY;
                M_PLAY: begin
                    if (goal_p1 && goal_p2) begin
                        m_mode = M_PAUSE; m_frames = 0;
                    end else if (goal_p1 || goal_p2) begin
                        if (goal_p1) begin
                            m_s1 = (m_s1 + 1 > WIN) ? WIN : m_s1 + 1; m_dir = 0;
                        end else begin
                            m_s2 = (m_s2 + 1 > WIN) ? WIN : m_s2 + 1; m_dir = 1;
                        end
                        m_frames = 0;
                        if (m_s1 == WIN || m_s2 == WIN) begin
                            m_mode = M_OVER; m_win = goal_p2 ? 1 : 0;
                        end else begin
                            m_mode = M_PAUSE;
                        end
                    end
                end
                M_PAUSE: if (m_tick_pend) begin
                    m_frames++;
                    if (m_frames == PF) begin m_frames = 0; m_mode = M_SERVE; end
                end
                default: if (m_start_pend) begin
                    m_mode = M_IDLE; m_s1 = 0; m_s2 = 0; m_dir = 1; m_win = 0;
                end
            endcase
            m_tick_pend  = m_armed && vblnk_in && !m_vb_prev;
            m_start_pend = m_armed && start_btn && !m_st_prev;
            m_vb_prev = vblnk_in;
            m_st_prev = start_btn;
            m_armed = 1;
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (check_en) begin
            cmp("p1_score", player1_score, m_s1);
            cmp("p2_score", player2_score, m_s2);
            cmp("ball_enable", ball_enable, (m_mode == M_PLAY) ? 1 : 0);
            cmp("serve_dir", serve_dir, m_dir);
            cmp("game_over", game_over, (m_mode == M_OVER) ? 1 : 0);
            cmp("winner", winner, m_win);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_start();
        start_btn = 1'b1; cyc(1);
        start_btn = 1'b0; cyc(2);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            vblnk_in = 1'b1; cyc(1);
            vblnk_in = 1'b0; cyc(1);
        end
        cyc(2);
    endtask

    // Goal pulse for one cycle; returns at the negedge after it was consumed.
    task automatic goal(input bit g1, input bit g2);
        goal_p1 = g1; goal_p2 = g2; cyc(1);
        goal_p1 = 1'b0; goal_p2 = 1'b0;
    endtask

    initial begin
        // Reset with the button held through release.
        rst = 1'b0; start_btn = 1'b1;
        cyc(3);
        rst = 1'b1;
        check_en = 1;
        cyc(4);
        cmp("lit_reset_p1", player1_score, 0);
        cmp("lit_reset_p2", player2_score, 0);
        cmp("lit_reset_dir", serve_dir, 1);
        cmp("lit_reset_ball", ball_enable, 0);
        start_btn = 1'b0; cyc(2);
        press_start();
        cmp("lit_idle_to_serve_ball", ball_enable, 0);
        press_start();
        cmp("lit_play_ball", ball_enable, 1);

        // First point to player 1.
        goal(1, 0);
        cmp("lit_goal1_score", player1_score, 1);
        cmp("lit_goal1_ball", ball_enable, 0);
        cmp("lit_goal1_dir", serve_dir, 0);
        frames(PF - 1);
        press_start();
        cmp("lit_pause_ignores_start", ball_enable, 0);
        frames(1);
        press_start();
        cmp("lit_serve_after_pause", ball_enable, 1);

        // Replayed point.
        goal(1, 1);
        cmp("lit_double_p1", player1_score, 1);
        cmp("lit_double_p2", player2_score, 0);
        cmp("lit_double_dir", serve_dir, 0);
        cyc(1);

        // Goals in PAUSE and SERVE are ignored.
        goal(0, 1); cyc(1); goal(1, 0);
        frames(PF);
        goal(0, 1); cyc(1); goal(1, 0);
        cmp("lit_ignored_p1", player1_score, 1);
        cmp("lit_ignored_p2", player2_score, 0);

        // Player 2 up to 8, then the winning goal.
        repeat (8) begin
            press_start();
            goal(0, 1);
            frames(PF);
        end
        cmp("lit_p2_eight", player2_score, 8);
        press_start();
        goal(0, 1);
        cmp("lit_win_score", player2_score, 9);
        cmp("lit_win_over", game_over, 1);
        cmp("lit_win_winner", winner, 1);
        cmp("lit_win_ball", ball_enable, 0);
        cyc(2);
        goal(0, 1);
        cmp("lit_win_sat", player2_score, 9);
        press_start();
        cmp("lit_restart_p1", player1_score, 0);
        cmp("lit_restart_p2", player2_score, 0);
        cmp("lit_restart_over", game_over, 0);

        // Asynchronous reset in the middle of a pause.
        press_start(); press_start();
        goal(1, 0);
        frames(30);
        cmp("lit_prereset_p1", player1_score, 1);
        #3 rst = 1'b0;
        #1;
        cmp("lit_async_p1", player1_score, 0);
        cmp("lit_async_dir", serve_dir, 1);
        cmp("lit_async_ball", ball_enable, 0);
        cmp("lit_async_over", game_over, 0);
        cyc(2);
        rst = 1'b1;
        cyc(2);

        // Randomized play against the model.
        for (int i = 0; i < 20000; i++) begin
            vblnk_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) start_btn = ~start_btn;
            goal_p1 = ($urandom_range(0, 9) == 0);
            goal_p2 = ($urandom_range(0, 9) == 0);
            cyc(1);
        end
        goal_p1 = 1'b0; goal_p2 = 1'b0;
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
